// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencer for the lab's negative-edge serial shift register. A parallel
// word is accepted on a start strobe. The register is cleared for one cycle,
// and the word is then shifted in through sr_si. Zeros follow the word until
// its last bit has fallen out of the chain. The bits seen on sr_so are
// gathered back into a parallel word, and that word is compared with the word
// that was sent.
//
// Parameters
//   DATA_W    bits per transferred word (>= 1)
//   DEPTH     number of stages in the controlled shift register (>= 1)
//   MSB_FIRST 1: tx_data[DATA_W-1] is shifted first, 0: bit 0 first
//   CNT_W     shift counter width, derived so that it covers DATA_W+DEPTH-1
//
// Ports
//   clk      rising-edge clock for all controller state
//   rst      synchronous active-high reset, aborts any transfer
//   start    transfer request, honoured only while idle
//   hold     pause, stops shifting and capture while high during SHIFT
//   tx_data  word to send, sampled when start is accepted
//   sr_so    serial output of the shift register
//   sr_clr   synchronous clear to the shift register
//   sr_ce    shift enable to the shift register
//   sr_si    serial input to the shift register
//   busy     high from the clear cycle through the done cycle
//   done     one-cycle completion pulse
//   rx_data  captured word, held until the next completion
//   match    rx_data equals the word that was sent, valid from done onward
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(DATA_W + DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              sr_so,
  output logic              sr_clr,
  output logic              sr_ce,
  output logic              sr_si,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              match
);

  localparam int NSHIFT = DATA_W + DEPTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_sh_nxt;
  logic [DATA_W-1:0] rx_cap;
  logic              step;
  logic              capture;
  logic              last;
  logic              si_bit;

  // A shift happens in every SHIFT cycle that is not paused. The hold input
  // gates the enable in the same cycle. The register then skips that
  // cycle's falling edge, and the counter and capture skip the rising edge
  // that ends it. The counter always equals the number of shifts already
  // done, so it is the index of the shift now in progress.
  always_comb begin
    step    = (state == SHIFT) && !hold;
    capture = int'(cnt) >= (DEPTH - 1);
    last    = int'(cnt) == (NSHIFT - 1);
  end

  // Serial data for shift index j comes from the latched word while j is
  // within the word, and is 0 after that to flush the chain. Bit order
  // follows MSB_FIRST. The bit is forced to 0 whenever the enable is low.
  always_comb begin
    si_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(cnt) == ((MSB_FIRST != 0) ? (DATA_W - 1 - i) : i)) begin
        si_bit = tx_q[i];
      end
    end
    sr_ce = step;
    sr_si = step && si_bit;
  end

  // The first word bit reaches sr_so after DEPTH shifts. Shift index j
  // therefore returns word position k = j - (DEPTH-1). That position goes
  // into the same bit of rx that sr_si took it from, so a healthy chain
  // reproduces the latched word exactly.
  always_comb begin
    rx_cap = rx_sh;
    for (int i = 0; i < DATA_W; i++) begin
      if ((int'(cnt) - (DEPTH - 1)) == ((MSB_FIRST != 0) ? (DATA_W - 1 - i) : i)) begin
        rx_cap[i] = sr_so;
      end
    end
  end

  // Next-state logic. CLEAR zeroes the counter and the capture word while
  // the shift register clears itself. SHIFT advances only on unpaused
  // cycles and leaves after the last shift. DONE always returns to IDLE, so
  // a start seen there is dropped and nothing is queued.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rx_sh_nxt = rx_sh;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        rx_sh_nxt = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (step) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (capture) begin
            rx_sh_nxt = rx_cap;
          end
          if (last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered outputs. sr_clr, busy and done are
  // decoded from the next state, so each one is a flop that lines up with
  // its state. rx_data and match load on the same edge that takes in the
  // last captured bit, so they are already valid while done is high. Reset
  // takes priority and abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_q    <= '0;
      rx_sh   <= '0;
      sr_clr  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      match   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rx_sh  <= rx_sh_nxt;
      sr_clr <= (state_nxt == CLEAR);
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      if ((state == IDLE) && start) begin
        tx_q <= tx_data;
      end
      if (state_nxt == DONE) begin
        rx_data <= rx_sh_nxt;
        match   <= (rx_sh_nxt == tx_q);
      end
    end
  end

endmodule
